shift_sequencer: RTL



---
 rtl/shift_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA engine for the execute stage. It shifts up to SHIFT_STEP
// bit positions per cycle and holds the pipeline through Stall_Req while it works.
//
// state   | meaning
// S_IDLE  | waiting for an accepted shift request
// S_SHIFT | shifting W by up to SHIFT_STEP per edge until C reaches 0
// S_DONE  | Result valid, Done high for this one cycle
module shift_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start,
  input  logic [3:0]            ALU_Control,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic                  Flush,
  output logic                  Stall_Req,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SRA = 4'd9;
  localparam logic [4:0] STEP    = 5'(SHIFT_STEP);

  if (!(SHIFT_STEP == 1 || SHIFT_STEP == 2 || SHIFT_STEP == 4)) begin : g_bad_step
    $error("shift_sequencer: SHIFT_STEP must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] work;
  logic [4:0]            cnt;
  logic [3:0]            op;
  logic [4:0]            step;
  logic [4:0]            cnt_nxt;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  is_shift;
  logic                  accept;
  logic                  unused_srcb;

  assign unused_srcb = ^SrcB[DATA_WIDTH-1:5];

  assign is_shift  = (ALU_Control == ALU_SLL) || (ALU_Control == ALU_SRL) ||
                     (ALU_Control == ALU_SRA);
  assign accept    = Start && is_shift && !Flush && (state != S_SHIFT);
  assign Stall_Req = !Flush && (accept || (state == S_SHIFT));

  // Step is clamped to the remaining count so C never wraps.
  always_comb begin
    step    = (cnt < STEP) ? cnt : STEP;
    cnt_nxt = cnt - step;
    case (op)
      ALU_SLL: shifted = work << step;
      ALU_SRA: shifted = $unsigned($signed(work) >>> step);
      default: shifted = work >> step;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      work   <= '0;
      cnt    <= '0;
      op     <= '0;
      Result <= '0;
      Done   <= 1'b0;
      Busy   <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (Flush) begin
        state <= S_IDLE;
        Busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (accept) begin
              work <= SrcA;
              cnt  <= SrcB[4:0];
              op   <= ALU_Control;
              Busy <= 1'b1;
              if (SrcB[4:0] == 5'd0) begin
                Result <= SrcA;
                Done   <= 1'b1;
                state  <= S_DONE;
              end else begin
                state <= S_SHIFT;
              end
            end else begin
              state <= S_IDLE;
              Busy  <= 1'b0;
            end
          end
          S_SHIFT: begin
            work <= shifted;
            cnt  <= cnt_nxt;
            if (cnt_nxt == 5'd0) begin
              Result <= shifted;
              Done   <= 1'b1;
              state  <= S_DONE;
            end
          end
          default: begin
            state <= S_IDLE;
            Busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
